// File: rtl/demod_llr_quantizer_if.sv
// rtl/demod_llr_quantizer_if.sv - RAM read-out / LLR stream bundle for the LLR quantizer
interface demod_llr_quantizer_if #(
  parameter int CodeLen_bits = 8,
  parameter int SampleW      = 15,
  parameter int LLRW         = 6
);
  logic                    start;
  logic                    demodulation_read_RAM;
  logic                    RAM_read_receive;
  logic                    demodulation_valid_a;
  logic                    demodulation_valid_b;
  logic [SampleW-1:0]      douta;
  logic [SampleW-1:0]      doutb;
  logic                    llr_valid;
  logic [CodeLen_bits-1:0] llr_addr;
  logic [LLRW-1:0]         llr_a;
  logic [LLRW-1:0]         llr_b;
  logic                    hard_a;
  logic                    hard_b;
  logic                    busy;
  logic                    demod_done;
  logic                    demod_error;

  // Upstream side: frame trigger, RAM acknowledge and sample pairs
  modport master (
    output start, RAM_read_receive, demodulation_valid_a, demodulation_valid_b, douta, doutb,
    input  demodulation_read_RAM, llr_valid, llr_addr, llr_a, llr_b, hard_a, hard_b,
           busy, demod_done, demod_error
  );

  // Quantizer side
  modport slave (
    input  start, RAM_read_receive, demodulation_valid_a, demodulation_valid_b, douta, doutb,
    output demodulation_read_RAM, llr_valid, llr_addr, llr_a, llr_b, hard_a, hard_b,
           busy, demod_done, demod_error
  );
endinterface

// File: rtl/demod_llr_quantizer.sv
// rtl/demod_llr_quantizer.sv - sample-pair to saturated LLR / hard-decision converter
module demod_llr_quantizer #(
  parameter int CodeLen      = 256,
  parameter int CodeLen_bits = 8,
  parameter int SampleW      = 15,
  parameter int LLRW         = 6,
  parameter int SHIFT        = 9,
  parameter int TIMEOUT      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  demod_llr_quantizer_if.slave bus
);
  localparam int PAIRS = CodeLen / 2;
  localparam int WDW   = $clog2(TIMEOUT + 1);

  localparam logic signed [SampleW:0] W_RND  = (SampleW+1)'(1 << (SHIFT - 1));
  localparam logic signed [SampleW:0] W_LMAX = (SampleW+1)'((1 << (LLRW - 1)) - 1);
  localparam logic signed [SampleW:0] W_LMIN = -W_LMAX;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RECV, ST_DRAIN} state_t;

  state_t                  r_state;
  logic [CodeLen_bits-1:0] r_pairs;
  logic [WDW-1:0]          r_wd;
  logic                    r_read;
  logic                    r_llr_valid;
  logic [CodeLen_bits-1:0] r_addr;
  logic [LLRW-1:0]         r_llr_a;
  logic [LLRW-1:0]         r_llr_b;
  logic                    r_hard_a;
  logic                    r_hard_b;
  logic                    r_done;
  logic                    r_error;

  logic                    w_pair;
  logic                    w_one;
  logic                    w_accept;
  logic                    w_last;
  logic [CodeLen_bits-1:0] w_pairs_next;

  // Round half up, then clamp symmetrically so +max and -max have equal magnitude
  function automatic logic [LLRW-1:0] to_llr(input logic [SampleW-1:0] s);
    logic signed [SampleW:0] w_ext;
    logic signed [SampleW:0] w_t;
    w_ext = signed'({s[SampleW-1], s});
    w_t   = (w_ext + W_RND) >>> SHIFT;
    if (w_t > W_LMAX) return W_LMAX[LLRW-1:0];
    if (w_t < W_LMIN) return W_LMIN[LLRW-1:0];
    return w_t[LLRW-1:0];
  endfunction

  assign w_pair       = bus.demodulation_valid_a & bus.demodulation_valid_b;
  assign w_one        = bus.demodulation_valid_a ^ bus.demodulation_valid_b;
  // A pair riding on the acknowledge cycle is already part of the frame
  assign w_accept     = w_pair && ((r_state == ST_RECV) ||
                                   (r_state == ST_REQ && bus.RAM_read_receive));
  assign w_pairs_next = r_pairs + 1'b1;
  assign w_last       = w_accept && (w_pairs_next == CodeLen_bits'(PAIRS));

  // Frame control FSM plus registered conversion datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pairs     <= '0;
      r_wd        <= '0;
      r_read      <= 1'b0;
      r_llr_valid <= 1'b0;
      r_addr      <= '0;
      r_llr_a     <= '0;
      r_llr_b     <= '0;
      r_hard_a    <= 1'b0;
      r_hard_b    <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_llr_valid <= 1'b0;
      r_done      <= 1'b0;
      if (w_accept) begin
        r_llr_valid <= 1'b1;
        r_addr      <= {r_pairs[CodeLen_bits-2:0], 1'b0};
        r_llr_a     <= to_llr(bus.douta);
        r_llr_b     <= to_llr(bus.doutb);
        r_hard_a    <= bus.douta[SampleW-1];
        r_hard_b    <= bus.doutb[SampleW-1];
        r_pairs     <= w_pairs_next;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_REQ;
            r_read  <= 1'b1;
            r_pairs <= '0;
            r_error <= 1'b0;
          end
        end
        ST_REQ: begin
          if (bus.RAM_read_receive) begin
            r_read  <= 1'b0;
            r_wd    <= '0;
            r_state <= w_last ? ST_DRAIN : ST_RECV;
          end
        end
        ST_RECV: begin
          if (w_pair) begin
            r_wd <= '0;
            if (w_last) r_state <= ST_DRAIN;
          end else if (w_one) begin
            r_error <= 1'b1;
          end else if (r_wd == WDW'(TIMEOUT - 1)) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Surplus pairs from the RAM sequencer are absorbed silently
          if (!bus.demodulation_valid_a && !bus.demodulation_valid_b) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.demodulation_read_RAM = r_read;
  assign bus.llr_valid             = r_llr_valid;
  assign bus.llr_addr              = r_addr;
  assign bus.llr_a                 = r_llr_a;
  assign bus.llr_b                 = r_llr_b;
  assign bus.hard_a                = r_hard_a;
  assign bus.hard_b                = r_hard_b;
  assign bus.busy                  = (r_state != ST_IDLE);
  assign bus.demod_done            = r_done;
  assign bus.demod_error           = r_error;
endmodule
